// File: rtl/key_pkg.sv
// Shared types for the push-button debounce path: FSM state encoding and a
// constant-evaluable clog2 for sizing counters from parameters.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin; both flops reset to RST_VAL so
// the pin does not look like an edge when reset is released.
module key_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_filter.sv
// Debounced push-button front end: synchronises the pin, qualifies level changes
// over DEBOUNCE_CYCLES samples and emits press / release / long-press strobes.
module key_debounce_filter
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 0,
    parameter int ACTIVE_LOW        = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_out,
    output logic key_pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int          CW        = clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic        IDLE_LVL  = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic        LONG_EN   = (LONG_PRESS_CYCLES != 0);
    // Saturating at LONG_PRESS_CYCLES makes long_pulse one-shot per press.
    localparam logic [31:0] HOLD_MAX  = LONG_EN ? 32'(LONG_PRESS_CYCLES) : 32'hFFFF_FFFF;
    localparam logic [31:0] HOLD_LONG = 32'(LONG_PRESS_CYCLES - 1);

    key_state_e      state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [31:0]     hold, hold_n, hold_inc;
    logic            pin_s, p_s;
    logic            pressed_n, press_n, release_n, long_n;

    key_sync_2ff #(.RST_VAL(IDLE_LVL)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_raw),
        .q     (pin_s)
    );

    assign p_s      = pin_s ^ IDLE_LVL;
    assign hold_inc = (hold == HOLD_MAX) ? hold : hold + 32'd1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hold_n    = hold;
        pressed_n = key_pressed;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        case (state)
            IDLE: begin
                if (p_s) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!p_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n   = PRESSED;
                    cnt_n     = '0;
                    pressed_n = 1'b1;
                    press_n   = 1'b1;
                    hold_n    = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PRESSED: begin
                hold_n = hold_inc;
                long_n = LONG_EN && (hold != hold_inc) && (hold_inc == HOLD_LONG);
                if (!p_s) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                // hold is frozen here and resumes if the release was a glitch.
                if (p_s) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    pressed_n = 1'b0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                cnt_n     = '0;
                pressed_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            hold          <= '0;
            key_pressed   <= 1'b0;
            key_out       <= IDLE_LVL;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            hold          <= hold_n;
            key_pressed   <= pressed_n;
            key_out       <= pressed_n ^ IDLE_LVL;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
        end
    end

endmodule

// File: tb/tb_key_debounce_filter.sv
// Directed bench for key_debounce_filter (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16,
// active-low pin). Checked vector is {key_out, key_pressed, press, release, long}.
module tb_key_debounce_filter;

    logic clk = 1'b0;
    logic reset;
    logic key_raw;
    logic key_out, key_pressed, press_pulse, release_pulse, long_pulse;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [4:0] IDLEV = 5'b10000;
    localparam logic [4:0] HELD  = 5'b01000;
    localparam logic [4:0] PRESS = 5'b01100;
    localparam logic [4:0] REL   = 5'b10010;
    localparam logic [4:0] LONG  = 5'b01001;

    key_debounce_filter #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (16),
        .ACTIVE_LOW        (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_raw       (key_raw),
        .key_out       (key_out),
        .key_pressed   (key_pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    // Advance one edge, then check outputs 1 time unit later.
    task automatic cyc(input logic [4:0] exp, input string tag);
        logic [4:0] obs;
        @(posedge clk);
        #1;
        obs = {key_out, key_pressed, press_pulse, release_pulse, long_pulse};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic run(input int n, input logic [4:0] exp, input string tag);
        for (int i = 0; i < n; i++) cyc(exp, tag);
    endtask

    initial begin
        reset   = 1'b1;
        key_raw = 1'b0;

        // Reset with the key held: idle outputs, then a fresh press 6 edges later.
        run(3, IDLEV, "reset_state");
        reset = 1'b0;
        run(5, IDLEV, "post_reset_wait");
        cyc(PRESS, "post_reset_press");
        cyc(HELD,  "post_reset_held");
        key_raw = 1'b1;
        run(5, HELD, "post_reset_release_wait");
        cyc(REL,   "post_reset_release");
        run(3, IDLEV, "idle_gap1");

        // Clean press held 30 cycles: press at t+6, long at t+21, release at t+36.
        key_raw = 1'b0;
        run(5, IDLEV, "clean_press_wait");
        cyc(PRESS, "clean_press");
        run(14, HELD, "long_wait");
        cyc(LONG,  "long_pulse");
        run(9, HELD, "long_after");
        key_raw = 1'b1;
        run(5, HELD, "long_release_wait");
        cyc(REL,   "long_release");
        run(3, IDLEV, "idle_gap2");

        // Bounce: 3 low, 1 high, 3 low, then high; never qualifies.
        key_raw = 1'b0;
        run(3, IDLEV, "bounce_a");
        key_raw = 1'b1;
        run(1, IDLEV, "bounce_b");
        key_raw = 1'b0;
        run(3, IDLEV, "bounce_c");
        key_raw = 1'b1;
        run(8, IDLEV, "bounce_tail");

        // Release glitch: pin high 2 cycles while pressed is rejected.
        key_raw = 1'b0;
        run(5, IDLEV, "glitch_press_wait");
        cyc(PRESS, "glitch_press");
        key_raw = 1'b1;
        run(2, HELD, "glitch_high");
        key_raw = 1'b0;
        run(3, HELD, "glitch_back_low");
        key_raw = 1'b1;
        run(5, HELD, "glitch_release_wait");
        cyc(REL,   "glitch_release");
        run(2, IDLEV, "idle_gap3");

        // Reset mid-press: outputs idle, no release strobe, press re-qualifies.
        key_raw = 1'b0;
        run(5, IDLEV, "midreset_press_wait");
        cyc(PRESS, "midreset_press");
        run(3, HELD, "midreset_held");
        reset = 1'b1;
        run(2, IDLEV, "midreset_in_reset");
        reset = 1'b0;
        run(5, IDLEV, "midreset_requalify_wait");
        cyc(PRESS, "midreset_repress");
        run(2, HELD, "midreset_reheld");
        key_raw = 1'b1;
        run(5, HELD, "midreset_release_wait");
        cyc(REL,   "midreset_release");
        run(3, IDLEV, "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
